// File: rtl/axis_intra_cycle_align_pkg.sv
// Shared constants for the photonic receive path: sample geometry, offset width
// and aligner FSM encodings, so the delay emulator and aligner index samples alike.
package axis_intra_cycle_align_pkg;

  localparam int ALIGN_SAMPLE_WIDTH = 16;
  localparam int ALIGN_SAMPLES      = 16;
  localparam int ALIGN_OFFSET_WIDTH = $clog2(ALIGN_SAMPLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } align_state_t;

endpackage

// File: rtl/axis_intra_cycle_align_encoder.sv
// Combinational calibration-pulse detector: flags a valid beat with any sample
// signed-above threshold and reports the lowest such sample index.
module sample_threshold_priority_encoder
  import axis_intra_cycle_align_pkg::*;
#(
  parameter int SAMPLE_WIDTH     = ALIGN_SAMPLE_WIDTH,
  parameter int SAMPLE_PER_CYCLE = ALIGN_SAMPLES,
  parameter int K_WIDTH          = $clog2(SAMPLE_PER_CYCLE)
) (
  input  logic [SAMPLE_WIDTH*SAMPLE_PER_CYCLE-1:0] data,
  input  logic                                     valid,
  input  logic [SAMPLE_WIDTH-1:0]                  threshold,
  output logic                                     hit,
  output logic [K_WIDTH-1:0]                       k_hit
);

  logic any_over;

  // Scan from the top down so the lowest exceeding index is the last one written.
  always_comb begin
    any_over = 1'b0;
    k_hit    = '0;
    for (int i = SAMPLE_PER_CYCLE - 1; i >= 0; i--) begin
      if ($signed(data[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]) > $signed(threshold)) begin
        any_over = 1'b1;
        k_hit    = K_WIDTH'(i);
      end
    end
  end

  assign hit = valid & any_over;

endmodule

// File: rtl/axis_intra_cycle_align.sv
// Sub-cycle deskew: locks the sample offset of a calibration pulse and re-packs
// every following beat so that the pulse sample lands at sample 0.
module axis_intra_cycle_align
  import axis_intra_cycle_align_pkg::*;
#(
  parameter int DATA_WIDTH       = 256,
  parameter int SAMPLE_WIDTH     = ALIGN_SAMPLE_WIDTH,
  parameter int SAMPLE_PER_CYCLE = ALIGN_SAMPLES,
  parameter int SEARCH_TIMEOUT   = 1024
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DATA_WIDTH-1:0]               s_axis_tdata,
  input  logic                                s_axis_tvalid,
  input  logic                                s_axis_tlast,
  input  logic                                cfg_calibrate,
  input  logic [SAMPLE_WIDTH-1:0]             cfg_threshold,
  output logic [DATA_WIDTH-1:0]               m_axis_tdata,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  output logic [$clog2(SAMPLE_PER_CYCLE)-1:0] offset,
  output logic                                locked,
  output logic                                cal_timeout
);

  localparam int OFFSET_WIDTH = $clog2(SAMPLE_PER_CYCLE);
  localparam int CNT_WIDTH    = $clog2(SEARCH_TIMEOUT + 1);

  logic [DATA_WIDTH-1:0]   d0_data, d1_data;
  logic                    d0_valid, d1_valid;
  logic                    d0_last, d1_last;
  logic                    hit;
  logic [OFFSET_WIDTH-1:0] k_hit;
  align_state_t            state_q, state_d;
  logic                    load_offset, set_timeout;
  logic [CNT_WIDTH-1:0]    count_q;
  logic [2*DATA_WIDTH-1:0] pair;
  logic [DATA_WIDTH-1:0]   aligned;

  sample_threshold_priority_encoder #(
    .SAMPLE_WIDTH     (SAMPLE_WIDTH),
    .SAMPLE_PER_CYCLE (SAMPLE_PER_CYCLE),
    .K_WIDTH          (OFFSET_WIDTH)
  ) u_encoder (
    .data      (s_axis_tdata),
    .valid     (s_axis_tvalid),
    .threshold (cfg_threshold),
    .hit       (hit),
    .k_hit     (k_hit)
  );

  // Invalid beats load zeros so vacated tail samples after a packet read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      d0_data  <= '0;
      d0_valid <= 1'b0;
      d0_last  <= 1'b0;
      d1_data  <= '0;
      d1_valid <= 1'b0;
      d1_last  <= 1'b0;
    end else begin
      d0_data  <= s_axis_tvalid ? s_axis_tdata : '0;
      d0_valid <= s_axis_tvalid;
      d0_last  <= s_axis_tvalid & s_axis_tlast;
      d1_data  <= d0_data;
      d1_valid <= d0_valid;
      d1_last  <= d0_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // A calibrate request overrides everything, including a hit in the same cycle.
  always_comb begin
    state_d     = state_q;
    load_offset = 1'b0;
    set_timeout = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_SEARCH: begin
        if (hit) begin
          state_d     = ST_LOCKED;
          load_offset = 1'b1;
        end else if (s_axis_tvalid && count_q == CNT_WIDTH'(SEARCH_TIMEOUT - 1)) begin
          state_d     = ST_IDLE;
          set_timeout = 1'b1;
        end
      end
      ST_LOCKED: state_d = ST_LOCKED;
      default:   state_d = ST_IDLE;
    endcase
    if (cfg_calibrate) begin
      state_d     = ST_SEARCH;
      load_offset = 1'b0;
      set_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      offset      <= '0;
      cal_timeout <= 1'b0;
    end else begin
      if (cfg_calibrate)
        count_q <= '0;
      else if (state_q == ST_SEARCH && s_axis_tvalid && count_q != CNT_WIDTH'(SEARCH_TIMEOUT))
        count_q <= count_q + 1'b1;
      if (load_offset)
        offset <= k_hit;
      if (cfg_calibrate)
        cal_timeout <= 1'b0;
      else if (set_timeout)
        cal_timeout <= 1'b1;
    end
  end

  assign locked = (state_q == ST_LOCKED);

  // Output sample j is sample j+k of the {d0,d1} pair, i.e. d1 shifted down by k samples.
  assign pair = {d0_data, d1_data};

  always_comb begin
    aligned = '0;
    for (int j = 0; j < SAMPLE_PER_CYCLE; j++) begin
      aligned[j*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
        pair[(j + int'(offset))*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      m_axis_tdata  <= aligned;
      m_axis_tvalid <= d1_valid;
      m_axis_tlast  <= d1_last;
    end
  end

endmodule
